// File: rtl/chan_rx_sync.sv
// chan_rx_sync: receiver for a 4-phase token-flow channel.
// The asynchronous request is brought into the clk domain through a
// 2-flop synchronizer. A 3-state handshake FSM captures each bundled
// word into a hold register and pushes it into a first-word-fall-through
// FIFO. When the FIFO is full, the acknowledge is withheld so that no
// token is lost.
// Optional feature: define CHAN_RX_STABLE_CHECK_EN to flag bundled data
// that changes between capture and push (sticky err).
module chan_rx_sync #(
    parameter int W     = 15,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ch_req,
    input  logic [W-1:0]             ch_data,
    output logic                     ch_ack,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              word_count,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SETTLE, WAIT_LOW} state_t;

    state_t         state;
    state_t         next_state;
    logic           req_meta;
    logic           req_s;
    logic [W-1:0]   d0;
    logic           capture;
    logic           push;
    logic           pop;
    logic           ack_set;
    logic           ack_clr;
    logic [W-1:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Two-flop synchronizer. This is the only logic that samples ch_req.
    // NOTE: sequential state uses non-blocking assignments, so each flop
    // samples the value its neighbour held before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_meta <= 1'b0;
            req_s    <= 1'b0;
        end else begin
            req_meta <= ch_req;
            req_s    <= req_meta;
        end
    end

    // Handshake FSM: the state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Handshake FSM: next state and the one-cycle control strobes.
    // NOTE: every output gets a default first, so no path infers a latch.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        push       = 1'b0;
        ack_set    = 1'b0;
        ack_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (!ch_ack && req_s && (fifo_count < CW'(DEPTH))) begin
                    capture    = 1'b1;
                    next_state = SETTLE;
                end
            end
            SETTLE: begin
                push       = 1'b1;
                ack_set    = 1'b1;
                next_state = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!req_s) begin
                    ack_clr    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Acknowledge, hold register and token counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_ack     <= 1'b0;
            d0         <= '0;
            word_count <= '0;
        end else begin
            if (ack_set)      ch_ack <= 1'b1;
            else if (ack_clr) ch_ack <= 1'b0;
            if (capture) d0 <= ch_data;
            if (push)    word_count <= word_count + 16'd1;
        end
    end

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    // The storage may hold stale words, so the head is gated to 0 while empty.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // FIFO storage. The FSM never pushes while the FIFO is full.
    // NOTE: the storage array has no reset. The count alone decides which
    // entries are valid, so clearing the array would add nothing.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= d0;
    end

    // FIFO pointers wrap naturally (DEPTH is a power of two). The count
    // distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef CHAN_RX_STABLE_CHECK_EN
    // Sticky error if the bundled data moved between capture and push.
    always_ff @(posedge clk) begin
        if (reset)                                err <= 1'b0;
        else if ((state == SETTLE) && (ch_data != d0)) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_chan_rx_sync.sv
// Testbench for chan_rx_sync. Directed stimulus drives the channel. Each
// issued token has its expected word queued, and a negedge monitor checks
// every popped head word against that queue.
module tb_chan_rx_sync;

    localparam int W     = 15;
    localparam int DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  ch_req;
    logic [W-1:0]          ch_data;
    logic                  ch_ack;
    logic                  out_valid;
    logic [W-1:0]          out_data;
    logic                  out_ready;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [15:0]           word_count;
    logic                  err;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    logic [W-1:0] exp_q [$];

    chan_rx_sync #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .ch_req     (ch_req),
        .ch_data    (ch_data),
        .ch_ack     (ch_ack),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .word_count (word_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Advance to just after the given edge number (1 time unit past it).
    task automatic step_to(input int k);
        while (edge_n < k) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    task automatic step(input int n);
        step_to(edge_n + n);
    endtask

    task automatic wait_ack(input logic v, input string name);
        int n = 0;
        while (ch_ack !== v && n < 40) begin
            step(1);
            n++;
        end
        check(name, 32'(ch_ack), 32'(v));
    endtask

    // One full 4-phase transfer, as a transmitter would drive it.
    task automatic send(input logic [W-1:0] w);
        ch_data = w;
        ch_req  = 1'b1;
        exp_q.push_back(w);
        wait_ack(1'b1, "send_ack_high");
        ch_req = 1'b0;
        wait_ack(1'b0, "send_ack_low");
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while (fifo_count != 0 && n < 40) begin
            step(1);
            n++;
        end
        check(name, 32'(fifo_count), 32'd0);
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        step(2);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: each pop must deliver the oldest expected word.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
            else                   check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        reset     = 1'b1;
        ch_req    = 1'b0;
        ch_data   = '0;
        out_ready = 1'b0;
        step_to(2);
        check("rst_ack", 32'(ch_ack), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_words", 32'(word_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        reset = 1'b0;

        // Single token with exact latencies.
        step_to(9);
        ch_data = 15'h1234;
        ch_req  = 1'b1;
        exp_q.push_back(15'h1234);
        step_to(12);
        check("lat_ack_e12", 32'(ch_ack), 32'd0);
        check("lat_valid_e12", 32'(out_valid), 32'd0);
        step_to(13);
        check("lat_ack_e13", 32'(ch_ack), 32'd1);
        check("lat_valid_e13", 32'(out_valid), 32'd1);
        check("lat_data_e13", 32'(out_data), 32'h1234);
        check("lat_words_e13", 32'(word_count), 32'd1);
        step_to(19);
        ch_req = 1'b0;
        step_to(21);
        check("lat_ack_e21", 32'(ch_ack), 32'd1);
        step_to(22);
        check("lat_ack_e22", 32'(ch_ack), 32'd0);
        drain("single_drain");
        out_ready = 1'b0;

        // Full FIFO and backpressure.
        for (int i = 1; i <= 4; i++) send(W'(i));
        check("full_count", 32'(fifo_count), 32'd4);
        ch_data = 15'd5;
        ch_req  = 1'b1;
        exp_q.push_back(15'd5);
        step(10);
        check("full_ack_held", 32'(ch_ack), 32'd0);
        check("full_count_held", 32'(fifo_count), 32'd4);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        wait_ack(1'b1, "full_fifth_ack");
        check("full_count_after", 32'(fifo_count), 32'd4);
        ch_req = 1'b0;
        wait_ack(1'b0, "full_fifth_low");
        drain("full_drain");
        out_ready = 1'b0;

        // Simultaneous push and pop at count 2.
        send(15'h0011);
        send(15'h0022);
        check("simul_pre", 32'(fifo_count), 32'd2);
        ch_data = 15'h0033;
        ch_req  = 1'b1;
        exp_q.push_back(15'h0033);
        step(3);
        check("simul_pre_ack", 32'(ch_ack), 32'd0);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("simul_push_ack", 32'(ch_ack), 32'd1);
        check("simul_count", 32'(fifo_count), 32'd2);
        ch_req = 1'b0;
        wait_ack(1'b0, "simul_low");
        drain("simul_drain");
        out_ready = 1'b0;

        // Reset mid-handshake while the token is still pending.
        ch_data = 15'h0077;
        ch_req  = 1'b1;
        wait_ack(1'b1, "mid_ack");
        reset = 1'b1;
        step(1);
        exp_q.delete();
        check("mid_rst_ack", 32'(ch_ack), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        exp_q.push_back(15'h0077);
        wait_ack(1'b1, "mid_recapture_ack");
        check("mid_words", 32'(word_count), 32'd1);
        check("mid_count", 32'(fifo_count), 32'd1);
        check("mid_data", 32'(out_data), 32'h0077);
        ch_req = 1'b0;
        wait_ack(1'b0, "mid_low");
        drain("mid_drain");
        out_ready = 1'b0;

        // Data changing between capture and push.
        ch_data = 15'h0AAA;
        ch_req  = 1'b1;
        exp_q.push_back(15'h0AAA);
        step(3);
        ch_data = 15'h0555;
        step(1);
        check("stab_ack", 32'(ch_ack), 32'd1);
        check("stab_data", 32'(out_data), 32'h0AAA);
`ifdef CHAN_RX_STABLE_CHECK_EN
        check("stab_err", 32'(err), 32'd1);
`else
        check("stab_err", 32'(err), 32'd0);
`endif
        ch_req = 1'b0;
        wait_ack(1'b0, "stab_low");
        drain("stab_drain");

        // Loopback stream from a transmitter model that reacts to ch_ack.
        do_reset();
        check("loop_rst_err", 32'(err), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(W'(i * (i + 1)));
        drain("loop_drain");
        check("loop_words", 32'(word_count), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
